// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared encodings for the 5-stage pipeline stall/flush scheduler:
//             FSM state codes, default register-address width, NOP word.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Scheduler FSM states; encodings are visible on state_o
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam int          REG_AW_DEF = 5;

    // addi x0,x0,0 - what IF_ID is cleared to on a flush
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Saturating up-counter used for pipeline performance statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Count qualifying cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Central stall/flush scheduler for the 5-stage CPU. Gates start-up,
//             load-use bubbles, taken-branch flushes, data-memory wait freezes
//             and end-of-program drain.
//  Config   : PIPE_PERF_CNT_EN - when defined, stall/flush/memwait saturating
//             counters are built; otherwise the *_cnt_o outputs are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int CNT_W        = 32,
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rd_addr_i,
    input  logic [REG_AW-1:0] ifid_rs1_addr_i,
    input  logic [REG_AW-1:0] ifid_rs2_addr_i,
    input  logic              ifid_uses_rs2_i,
    input  logic              branch_taken_i,
    input  logic              halt_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    output logic              pc_en_o,
    output logic              ifid_en_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_en_o,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  memwait_cnt_o
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t         state, state_nxt;
    logic [7:0]     wait_cnt, wait_nxt;
    logic [DW-1:0]  drain_cnt, drain_nxt;
    logic           err_set;
    logic           stall_inc, flush_inc, memwait_inc;
    logic           load_use, mem_stall;

    // Hazard detection on the raw stage contents
    always_comb begin
        load_use  = idex_memread_i && (idex_rd_addr_i != '0) &&
                    ((idex_rd_addr_i == ifid_rs1_addr_i) ||
                     (ifid_uses_rs2_i && (idex_rd_addr_i == ifid_rs2_addr_i)));
        mem_stall = dmem_req_i && !dmem_ready_i;
    end

    // Next-state and enable decode; memory stall outranks everything in RUN
    always_comb begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_en_o     = 1'b0;
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        drain_nxt     = drain_cnt;
        err_set       = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        memwait_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall) begin
                    // This cycle is the first not-ready cycle of the access
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = 8'd1;
                end else if (!start_i) begin
                    state_nxt = ST_IDLE;
                end else if (load_use) begin
                    // Branch operands are stale here; branch retried next cycle
                    idex_bubble_o = 1'b1;
                    pipe_en_o     = 1'b1;
                    stall_inc     = 1'b1;
                end else if (halt_i) begin
                    ifid_en_o    = 1'b1;
                    ifid_flush_o = 1'b1;
                    pipe_en_o    = 1'b1;
                    state_nxt    = ST_DRAIN;
                    drain_nxt    = '0;
                end else begin
                    pc_en_o      = 1'b1;
                    ifid_en_o    = 1'b1;
                    pipe_en_o    = 1'b1;
                    ifid_flush_o = branch_taken_i;
                    flush_inc    = branch_taken_i;
                end
            end
            ST_MEM_WAIT: begin
                memwait_inc = 1'b1;
                if (dmem_ready_i) begin
                    pipe_en_o = 1'b1;
                    state_nxt = start_i ? ST_RUN : ST_IDLE;
                end else if ((int'(wait_cnt) + 1) >= MEM_TIMEOUT) begin
                    err_set   = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (!start_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    idex_bubble_o = 1'b1;
                    if (!mem_stall) begin
                        pipe_en_o = 1'b1;
                        if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nxt = ST_HALT;
                        else                                    drain_nxt = drain_cnt + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (!start_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        state_o = state;
        done_o  = (state == ST_HALT);
    end

    // State, wait/drain counters and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            err_o     <= err_o | err_set;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_inc),
        .cnt_o   (stall_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (flush_inc),
        .cnt_o   (flush_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (memwait_inc),
        .cnt_o   (memwait_cnt_o)
    );
`else
    logic unused_inc;
    assign unused_inc    = ^{stall_inc, flush_inc, memwait_inc};
    assign stall_cnt_o   = '0;
    assign flush_cnt_o   = '0;
    assign memwait_cnt_o = '0;
`endif

endmodule
`default_nettype wire
